uart_tx_arbiter: RTL and testbench

- Shares one UART_TX transmitter between NUM_REQ byte-stream requesters, e.g. a debug logger, a command responder and a status reporter.
- Uses round-robin arbitration at message granularity. Once a requester is granted, it keeps the transmitter until it sends a byte flagged last, or until its lock times out.
- Sits between the requesters and UART_TX. It drives i_TX_DV and i_TX_Byte, and consumes o_TX_Active and o_TX_Done.

---
 rtl/uart_tx_arbiter.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-granular round-robin share of one UART_TX.
// Optional per-requester byte counters: define UART_ARB_CNT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic [NUM_REQ-1:0]     i_Req_Valid,
  input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
  input  logic [NUM_REQ-1:0]     i_Req_Last,
  output logic [NUM_REQ-1:0]     o_Req_Ready,
  output logic [NUM_REQ-1:0]     o_Grant,
  output logic                   o_Abort,
  output logic                   o_TX_DV,
  output logic [7:0]             o_TX_Byte,
  input  logic                   i_TX_Active,
  input  logic                   i_TX_Done,
  output logic                   o_Busy
`ifdef UART_ARB_CNT_EN
  ,
  output logic [16*NUM_REQ-1:0]  o_Byte_Count
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned NR = NUM_REQ;
  localparam logic [NUM_REQ-1:0] ONE = 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT
  } state_e;

  state_e               state_q;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        own_q;
  logic [CW-1:0]        cnt_q;
  logic                 last_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   ready_q;
  logic                 abort_q;
  logic                 dv_q;
  logic [7:0]           byte_q;
  logic                 busy_q;

  logic [IW-1:0]        pick_d;
  logic                 hit_d;

  // Index a + b modulo NUM_REQ; both operands are already below NUM_REQ.
  function automatic logic [IW-1:0] wrap_add(
    input logic [IW-1:0] a,
    input int unsigned   b
  );
    int unsigned s;
    s = 32'(a) + b;
    if (s >= NR) s = s - NR;
    return IW'(s);
  endfunction

  // First valid requester at or above the pointer, wrapping around.
  always_comb begin
    pick_d = ptr_q;
    hit_d  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_Req_Valid[wrap_add(ptr_q, i)]) begin
        pick_d = wrap_add(ptr_q, i);
        hit_d  = 1'b1;
      end
    end
  end

  // Grant/load/wait sequencer; every output is a register.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      grant_q <= '0;
      ready_q <= '0;
      abort_q <= 1'b0;
      dv_q    <= 1'b0;
      byte_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= '0;
      dv_q    <= 1'b0;
      abort_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (hit_d) begin
            own_q   <= pick_d;
            grant_q <= ONE << pick_d;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (i_Req_Valid[own_q]) begin
            // Hold off while the transmitter is still shifting.
            if (!i_TX_Active) begin
              byte_q  <= i_Req_Byte[{own_q, 3'b000} +: 8];
              last_q  <= i_Req_Last[own_q];
              dv_q    <= 1'b1;
              ready_q <= ONE << own_q;
              cnt_q   <= '0;
              state_q <= S_WAIT;
            end
          end else if (cnt_q == CNT_LAST) begin
            abort_q <= 1'b1;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= wrap_add(own_q, 1);
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (i_TX_Done) begin
            if (last_q) begin
              grant_q <= '0;
              busy_q  <= 1'b0;
              ptr_q   <= wrap_add(own_q, 1);
              state_q <= S_IDLE;
            end else begin
              state_q <= S_LOAD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_Req_Ready = ready_q;
  assign o_Grant     = grant_q;
  assign o_Abort     = abort_q;
  assign o_TX_DV     = dv_q;
  assign o_TX_Byte   = byte_q;
  assign o_Busy      = busy_q;

`ifdef UART_ARB_CNT_EN
  logic [16*NUM_REQ-1:0] bcnt_q;

  // Per-requester accepted-byte counters, wrapping at 16 bits.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      bcnt_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (ready_q[r]) begin
          bcnt_q[16*r +: 16] <= bcnt_q[16*r +: 16] + 16'd1;
        end
      end
    end
  end

  assign o_Byte_Count = bcnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: UART_TX/RX models plus a byte scoreboard.
// Define UART_ARB_CNT_EN to also exercise the byte counters.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int LT  = 16;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_byte;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   ready;
  logic [NR-1:0]   grant;
  logic            abort;
  logic            dv;
  logic [7:0]      tx_byte;
  logic            busy;
  logic            tx_active;
  logic            tx_done;
  logic            force_done;
  logic            tx_done_in;
  logic            tx_serial;

  assign tx_done_in = tx_done | force_done;

`ifdef UART_ARB_CNT_EN
  logic [16*NR-1:0] byte_count;
`endif

  uart_tx_arbiter #(
    .NUM_REQ(NR),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .i_Clock(clk),
    .i_Reset(rst_n),
    .i_Req_Valid(req_valid),
    .i_Req_Byte(req_byte),
    .i_Req_Last(req_last),
    .o_Req_Ready(ready),
    .o_Grant(grant),
    .o_Abort(abort),
    .o_TX_DV(dv),
    .o_TX_Byte(tx_byte),
    .i_TX_Active(tx_active),
    .i_TX_Done(tx_done_in),
    .o_Busy(busy)
`ifdef UART_ARB_CNT_EN
    ,
    .o_Byte_Count(byte_count)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int done_cyc = 0;
  int abort_cnt = 0;
  int abort_cyc = 0;

  logic [8:0] mem [NR][32];
  int head [NR];
  int tail [NR];
  logic [7:0] exp_q [$];

  // UART_TX model: start, 8 data LSB first, stop, then a done pulse.
  int tx_bit, tx_clk;
  logic [7:0] tx_sh;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      tx_serial <= 1'b1;
      tx_bit    <= 0;
      tx_clk    <= 0;
      tx_sh     <= 8'h00;
    end else begin
      tx_done <= 1'b0;
      if (!tx_active) begin
        if (dv) begin
          tx_active <= 1'b1;
          tx_sh     <= tx_byte;
          tx_bit    <= 0;
          tx_clk    <= 0;
          tx_serial <= 1'b0;
        end
      end else if (tx_clk < CPB - 1) begin
        tx_clk <= tx_clk + 1;
      end else begin
        tx_clk <= 0;
        if (tx_bit < 9) begin
          tx_bit    <= tx_bit + 1;
          tx_serial <= (tx_bit < 8) ? tx_sh[tx_bit[2:0]] : 1'b1;
        end else begin
          tx_active <= 1'b0;
          tx_done   <= 1'b1;
          tx_serial <= 1'b1;
        end
      end
    end
  end

  // UART_RX model; each received byte is popped against the scoreboard.
  int rx_st, rx_clk, rx_n;
  logic [7:0] rx_sh;
  logic [7:0] rx_e;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st  <= 0;
      rx_clk <= 0;
      rx_n   <= 0;
      rx_sh  <= 8'h00;
    end else if (rx_st == 0) begin
      if (!tx_serial) begin
        rx_st  <= 1;
        rx_clk <= 0;
        rx_n   <= 0;
      end
    end else begin
      rx_clk <= rx_clk + 1;
      if (rx_clk == CPB + 1 + CPB * rx_n) begin
        if (rx_n < 8) begin
          rx_sh <= {tx_serial, rx_sh[7:1]};
          rx_n  <= rx_n + 1;
        end else begin
          rx_st <= 0;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rx_unexpected got=%02h want=none", rx_sh);
          end else begin
            rx_e = exp_q.pop_front();
            if (rx_sh !== rx_e || tx_serial !== 1'b1) begin
              failures++;
              $display("FAIL rx_byte got=%02h want=%02h", rx_sh, rx_e);
            end
          end
        end
      end
    end
  end

  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      if (head[r] < tail[r]) begin
        req_valid[r]        = 1'b1;
        req_byte[8*r +: 8]  = mem[r][head[r]][7:0];
        req_last[r]         = mem[r][head[r]][8];
      end else begin
        req_valid[r]        = 1'b0;
        req_byte[8*r +: 8]  = 8'h00;
        req_last[r]         = 1'b0;
      end
    end
  endtask

  task automatic clear_reqs();
    for (int r = 0; r < NR; r++) begin
      head[r] = 0;
      tail[r] = 0;
    end
    drive();
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic l);
    mem[r][tail[r]] = {l, b};
    tail[r]++;
  endtask

  // One cycle: sample at negedge, retire accepted bytes, re-drive.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (dv) dv_cnt++;
    if (tx_done) done_cyc = cyc;
    if (abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    for (int r = 0; r < NR; r++) begin
      if (ready[r] && head[r] < tail[r]) head[r]++;
    end
    drive();
  endtask

  task automatic wait_exp(input int budget, output bit ok);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    ok = (exp_q.size() == 0);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (grant != '0 || busy); i++) step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_reqs();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_reqs();
    repeat (2) @(negedge clk);
    checks++;
    if ({grant, ready, abort, dv, tx_byte, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%0h want=0",
               {grant, ready, abort, dv, tx_byte, busy});
    end
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got=%0h/%0b want=0/0", grant, busy);
    end
  endtask

  task automatic test_single();
    int n0;
    bit ok;
    apply_reset();
    n0 = dv_cnt;
    push(0, 8'h3F, 1'b1);
    exp_q.push_back(8'h3F);
    step();
    step();
    checks++;
    if (grant !== 4'b0001 || busy !== 1'b1 || dv !== 1'b0) begin
      failures++;
      $display("FAIL single_grant got=%b/%0b/%0b want=0001/1/0",
               grant, busy, dv);
    end
    step();
    checks++;
    if (dv !== 1'b1 || tx_byte !== 8'h3F || ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_load got=%0b/%02h/%b want=1/3f/0001",
               dv, tx_byte, ready);
    end
    wait_exp(600, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_drain pending=%0d want=0", exp_q.size());
    end
    wait_idle(100);
    checks++;
    if (grant !== '0 || busy !== 1'b0 || dv_cnt - n0 !== 1) begin
      failures++;
      $display("FAIL single_release got=%b/%0b/%0d want=0000/0/1",
               grant, busy, dv_cnt - n0);
    end
    n0 = dv_cnt;
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    repeat (3) step();
    checks++;
    if (grant !== '0 || busy !== 1'b0 || dv_cnt !== n0) begin
      failures++;
      $display("FAIL stray_done got=%b/%0b/%0d want=0000/0/%0d",
               grant, busy, dv_cnt, n0);
    end
  endtask

  task automatic test_message();
    int n;
    logic [NR-1:0] want;
    n = 0;
    push(1, 8'h41, 1'b0);
    push(1, 8'h42, 1'b0);
    push(1, 8'h43, 1'b1);
    push(2, 8'h55, 1'b1);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h55);
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) begin
      step();
      if (dv) begin
        n++;
        want = (n <= 3) ? 4'b0010 : 4'b0100;
        checks++;
        if (grant !== want) begin
          failures++;
          $display("FAIL msg_owner%0d got=%b want=%b", n, grant, want);
        end
        if (n == 2 || n == 3) begin
          checks++;
          if (cyc - done_cyc !== 2) begin
            failures++;
            $display("FAIL msg_gap%0d got=%0d want=2", n, cyc - done_cyc);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || n != 4) begin
      failures++;
      $display("FAIL msg_drain got=%0d/%0d want=0/4", exp_q.size(), n);
    end
    wait_idle(100);
  endtask

  task automatic test_fairness();
    bit ok;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < NR; r++) begin
        push(r, 8'(8'h10 + r), 1'b1);
        exp_q.push_back(8'(8'h10 + r));
      end
    end
    wait_exp(2000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL fair_drain pending=%0d want=0", exp_q.size());
    end
    wait_idle(100);
  endtask

  task automatic test_timeout();
    bit got;
    bit ok;
    int a0;
    apply_reset();
    a0 = abort_cnt;
    got = 1'b0;
    push(3, 8'hA0, 1'b0);
    exp_q.push_back(8'hA0);
    for (int i = 0; i < 20 && grant != 4'b1000; i++) step();
    push(0, 8'h77, 1'b1);
    exp_q.push_back(8'h77);
    for (int i = 0; i < 400 && !got; i++) begin
      step();
      if (abort) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL abort_seen got=0 want=1");
    end else begin
      checks++;
      if (abort_cyc - done_cyc !== LT + 1) begin
        failures++;
        $display("FAIL abort_delay got=%0d want=%0d",
                 abort_cyc - done_cyc, LT + 1);
      end
      checks++;
      if (grant !== '0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_release got=%b/%0b want=0000/0", grant, busy);
      end
    end
    step();
    checks++;
    if (grant !== 4'b0001 || abort_cnt - a0 !== 1) begin
      failures++;
      $display("FAIL abort_next got=%b/%0d want=0001/1",
               grant, abort_cnt - a0);
    end
    wait_exp(600, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL abort_drain pending=%0d want=0", exp_q.size());
    end
    wait_idle(100);
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    apply_reset();
    push(1, 8'hC3, 1'b1);
    for (int i = 0; i < 200 && !(tx_active && tx_bit == 4); i++) step();
    checks++;
    if (grant !== 4'b0010 || busy !== 1'b1 || tx_bit !== 4) begin
      failures++;
      $display("FAIL midrst_pre got=%b/%0b/%0d want=0010/1/4",
               grant, busy, tx_bit);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, ready, abort, dv, tx_byte, busy} !== '0) begin
      failures++;
      $display("FAIL midrst_async got=%0h want=0",
               {grant, ready, abort, dv, tx_byte, busy});
    end
    clear_reqs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    push(2, 8'h5A, 1'b1);
    push(2, 8'h5B, 1'b1);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h5B);
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) begin
      step();
      if (dv) begin
        n++;
        checks++;
        if (grant !== 4'b0100) begin
          failures++;
          $display("FAIL regrant%0d got=%b want=0100", n, grant);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || n != 2) begin
      failures++;
      $display("FAIL midrst_drain got=%0d/%0d want=0/2", exp_q.size(), n);
    end
    wait_idle(100);
  endtask

`ifdef UART_ARB_CNT_EN
  task automatic test_count();
    bit ok;
    logic [16*NR-1:0] want;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      push(0, 8'(8'hB0 + i), (i == 4));
      exp_q.push_back(8'(8'hB0 + i));
    end
    for (int i = 0; i < 2; i++) begin
      push(1, 8'(8'hD0 + i), (i == 1));
      exp_q.push_back(8'(8'hD0 + i));
    end
    wait_exp(2000, ok);
    wait_idle(100);
    want = '0;
    want[15:0]  = 16'd5;
    want[31:16] = 16'd2;
    checks++;
    if (!ok || byte_count !== want) begin
      failures++;
      $display("FAIL byte_count got=%h want=%h", byte_count, want);
    end
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    force_done = 1'b0;
    req_valid  = '0;
    req_byte   = '0;
    req_last   = '0;
    clear_reqs();
    test_reset();
    test_single();
    test_message();
    test_fairness();
    test_timeout();
    test_reset_mid();
`ifdef UART_ARB_CNT_EN
    test_count();
`endif
    repeat (50) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
